// File: rtl/swd_pkg.sv
// Shared SWD host definitions: FSM encoding, ACK codes, phase lengths and header bit layout.
// Pure declarations; no timing or backpressure of its own.
package swd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LRST,
    ST_HDR,
    ST_TRN1,
    ST_ACK,
    ST_RDATA,
    ST_TRN2,
    ST_WDATA,
    ST_TAIL
  } state_t;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int LRST_BITS = 56;
  localparam int HDR_BITS  = 8;
  localparam int ACK_BITS  = 3;
  localparam int DATA_BITS = 32;

  localparam int HDR_START = 0;
  localparam int HDR_APNDP = 1;
  localparam int HDR_RNW   = 2;
  localparam int HDR_A2    = 3;
  localparam int HDR_A3    = 4;
  localparam int HDR_PAR   = 5;
  localparam int HDR_STOP  = 6;
  localparam int HDR_PARK  = 7;

  function automatic logic [7:0] swd_hdr(input logic apndp, input logic rnw,
                                         input logic [1:0] addr);
    logic [7:0] h;
    h            = '0;
    h[HDR_START] = 1'b1;
    h[HDR_APNDP] = apndp;
    h[HDR_RNW]   = rnw;
    h[HDR_A2]    = addr[0];
    h[HDR_A3]    = addr[1];
    h[HDR_PAR]   = apndp ^ rnw ^ addr[0] ^ addr[1];
    h[HDR_STOP]  = 1'b0;
    h[HDR_PARK]  = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/swd_clkgen.sv
// SWCLKTCK divider: toggles every CLK_DIV HCLK while run is high, idles low otherwise.
// rise/fall are single-cycle strobes in the HCLK cycle whose closing edge moves SWCLKTCK; no backpressure.
module swd_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic run,
  output logic swclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          swclk_q, swclk_d;
  logic          wrap;

  always_comb begin
    wrap    = run && (cnt_q == CNT_MAX);
    cnt_d   = '0;
    swclk_d = 1'b0;
    if (run) begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      swclk_d = swclk_q ^ wrap;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q   <= '0;
      swclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      swclk_q <= swclk_d;
    end
  end

  assign swclk = swclk_q;
  assign rise  = wrap & ~swclk_q;
  assign fall  = wrap & swclk_q;

endmodule

// File: rtl/swd_host.sv
// SWD host: one line reset or one DP/AP transfer per accepted request, finished by a rsp_valid pulse.
// Latency 46+IDLE_BITS (OK), 13+IDLE_BITS (non-OK) or 56+IDLE_BITS (line reset) SWCLK periods; req_ready low while busy, rsp has no backpressure.
module swd_host
  import swd_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int IDLE_BITS = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_linereset,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        SWCLKTCK,
  output logic        SWDIO_O,
  output logic        SWDIO_OE,
  input  logic        SWDIO_I
);

  state_t      state_q, state_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rnw_q, rnw_d;
  logic [2:0]  ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        perr_q, perr_d;
  logic        o_q, o_d;
  logic        oe_q, oe_d;

  logic        busy, rise, fall, last;
  logic [7:0]  plen;

  assign busy = (state_q != ST_IDLE);

  swd_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .run     (busy),
    .swclk   (SWCLKTCK),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    case (state_q)
      ST_LRST:  plen = 8'(LRST_BITS);
      ST_HDR:   plen = 8'(HDR_BITS);
      ST_ACK:   plen = 8'(ACK_BITS);
      ST_RDATA: plen = 8'(DATA_BITS + 1);
      ST_WDATA: plen = 8'(DATA_BITS + 1);
      ST_TAIL:  plen = 8'(IDLE_BITS);
      default:  plen = 8'd1;
    endcase
    last = (bcnt_q == plen - 8'd1);
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    hdr_d     = hdr_q;
    wdata_d   = wdata_q;
    rnw_d     = rnw_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    perr_d    = perr_q;
    rsp_valid = 1'b0;

    if (state_q == ST_IDLE && req_valid && req_ready) begin
      state_d = req_linereset ? ST_LRST : ST_HDR;
      bcnt_d  = '0;
      hdr_d   = swd_hdr(req_apndp, req_rnw, req_addr);
      wdata_d = req_wdata;
      rnw_d   = req_rnw;
      ack_d   = '0;
      rdata_d = '0;
      perr_d  = 1'b0;
    end

    // Target bits are captured on the edge that raises SWCLKTCK.
    if (rise) begin
      if (state_q == ST_ACK) begin
        ack_d[bcnt_q[1:0]] = SWDIO_I;
      end else if (state_q == ST_RDATA) begin
        if (bcnt_q < 8'(DATA_BITS)) rdata_d[bcnt_q[4:0]] = SWDIO_I;
        else                        perr_d = (^rdata_q) ^ SWDIO_I;
      end
    end

    if (fall) begin
      bcnt_d = last ? 8'd0 : bcnt_q + 8'd1;
      if (last) begin
        case (state_q)
          ST_LRST:  state_d = ST_TAIL;
          ST_HDR:   state_d = ST_TRN1;
          ST_TRN1:  state_d = ST_ACK;
          ST_ACK:   state_d = (ack_q == ACK_OK && rnw_q) ? ST_RDATA : ST_TRN2;
          ST_RDATA: state_d = ST_TRN2;
          ST_TRN2:  state_d = (ack_q == ACK_OK && !rnw_q) ? ST_WDATA : ST_TAIL;
          ST_WDATA: state_d = ST_TAIL;
          ST_TAIL: begin
            state_d   = ST_IDLE;
            rsp_valid = HRESETn;
          end
          default:  state_d = ST_IDLE;
        endcase
      end
    end

    // Pad drive follows the next state so it switches on the same edge SWCLKTCK falls.
    oe_d = 1'b1;
    o_d  = 1'b0;
    case (state_d)
      ST_LRST:  o_d = 1'b1;
      ST_HDR:   o_d = hdr_d[bcnt_d[2:0]];
      ST_WDATA: o_d = (bcnt_d < 8'(DATA_BITS)) ? wdata_d[bcnt_d[4:0]] : ^wdata_d;
      ST_TRN1, ST_ACK, ST_RDATA, ST_TRN2: oe_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      hdr_q   <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
      o_q     <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      hdr_q   <= hdr_d;
      wdata_q <= wdata_d;
      rnw_q   <= rnw_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
      o_q     <= o_d;
      oe_q    <= oe_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE) && HRESETn;
  assign rsp_ack        = ack_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_parity_err = perr_q;
  assign SWDIO_O        = o_q;
  assign SWDIO_OE       = oe_q;

endmodule
